// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock) feeding the seven-segment driver.
// Latency w cycles from accepting edge to result; start is ignored while busy; bcd/overflow hold between completions.
module bin_to_bcd_seq #(
    parameter int w     = 16,
    parameter int n_dig = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [w-1:0]       bin,
    output logic               busy,
    output logic               done,
    output logic [n_dig*4-1:0] bcd,
    output logic               overflow
);

    localparam int cw = $clog2(w + 1);
    localparam int bw = n_dig * 4;

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_conv = 1'b1;

    logic [0:0]    state;
    logic [cw-1:0] cnt;
    logic [w-1:0]  shreg;
    logic [bw-1:0] scratch;
    logic          sticky;

    logic [bw-1:0] adj;
    logic [bw-1:0] scratch_nxt;
    logic [w-1:0]  shreg_nxt;
    logic          carry;
    logic          last_iter;

    // Add-3 correction before the shift keeps every digit in 0..9 after doubling;
    // the bit leaving the top digit is the part of the value that no longer fits.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < n_dig; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
        {carry, scratch_nxt, shreg_nxt} = {adj, shreg, 1'b0};
    end

    assign last_iter = (cnt == cw'(1));
    assign busy      = (state == st_conv);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= st_idle;
            cnt      <= '0;
            shreg    <= '0;
            scratch  <= '0;
            sticky   <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= cw'(w);
                        state   <= st_conv;
                    end
                end
                default: begin
                    scratch <= scratch_nxt;
                    shreg   <= shreg_nxt;
                    sticky  <= sticky | carry;
                    cnt     <= cnt - cw'(1);
                    if (last_iter) begin
                        bcd      <= scratch_nxt;
                        overflow <= sticky | carry;
                        done     <= 1'b1;
                        state    <= st_idle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance share stimulus and are
// checked against a decimal model built from plain division/modulo.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] bin;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int n_checks;
    int n_fail;

    bin_to_bcd_seq #(.w(16), .n_dig(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
        .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5)
    );

    bin_to_bcd_seq #(.w(16), .n_dig(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] ref_bcd(input int v, input int nd);
        logic [19:0] o;
        int r;
        o = '0;
        r = v;
        for (int i = 0; i < nd; i++) begin
            o[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return o;
    endfunction

    function automatic logic ref_ovf(input int v, input int nd);
        return v >= (10 ** nd);
    endfunction

    task automatic launch(input logic [15:0] v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge just after the accepting edge; returns the negedge index
    // at which done5 was seen (0 on timeout) and how many of the preceding ones had busy.
    task automatic wait_done(output int cyc, output int bcnt, output bit clash);
        cyc   = 0;
        clash = 1'b0;
        bcnt  = busy5 ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done5 && busy5) clash = 1'b1;
            if (done5 !== done4) clash = 1'b1;
            if (done5) begin
                cyc = k;
                break;
            end
            if (busy5) bcnt++;
        end
    endtask

    task automatic check_result(input string name, input int v, input int cyc,
                                input int bcnt, input bit clash);
        logic [19:0] r5;
        logic [19:0] r4;
        r5 = ref_bcd(v, 5);
        r4 = ref_bcd(v, 4);
        n_checks += 7;
        if (cyc !== 16) begin
            n_fail++; $display("FAIL %s latency: got %0d want 16", name, cyc);
        end
        if (bcnt !== 16) begin
            n_fail++; $display("FAIL %s busy_cycles: got %0d want 16", name, bcnt);
        end
        if (clash !== 1'b0) begin
            n_fail++; $display("FAIL %s done_busy_overlap_or_done_mismatch", name);
        end
        if (bcd5 !== r5) begin
            n_fail++; $display("FAIL %s bcd5 bin=%0d: got %h want %h", name, v, bcd5, r5);
        end
        if (ovf5 !== ref_ovf(v, 5)) begin
            n_fail++; $display("FAIL %s ovf5 bin=%0d: got %b want %b", name, v, ovf5, ref_ovf(v, 5));
        end
        if (bcd4 !== r4[15:0]) begin
            n_fail++; $display("FAIL %s bcd4 bin=%0d: got %h want %h", name, v, bcd4, r4[15:0]);
        end
        if (ovf4 !== ref_ovf(v, 4)) begin
            n_fail++; $display("FAIL %s ovf4 bin=%0d: got %b want %b", name, v, ovf4, ref_ovf(v, 4));
        end
        @(negedge clk);
        n_checks++;
        if (done5 !== 1'b0 || busy5 !== 1'b0) begin
            n_fail++; $display("FAIL %s done_width: done=%b busy=%b want 0 0", name, done5, busy5);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = '0;
        repeat (3) @(negedge clk);
        n_checks += 2;
        if ({busy5, done5, ovf5, bcd5} !== 23'd0) begin
            n_fail++; $display("FAIL reset_dut5: busy=%b done=%b ovf=%b bcd=%h want all 0", busy5, done5, ovf5, bcd5);
        end
        if ({busy4, done4, ovf4, bcd4} !== 19'd0) begin
            n_fail++; $display("FAIL reset_dut4: busy=%b done=%b ovf=%b bcd=%h want all 0", busy4, done4, ovf4, bcd4);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        int vals[5] = '{0, 65535, 1234, 10000, 9999};
        int cyc, bcnt;
        bit clash;
        foreach (vals[i]) begin
            launch(16'(vals[i]));
            wait_done(cyc, bcnt, clash);
            check_result("directed", vals[i], cyc, bcnt, clash);
        end
    endtask

    task automatic test_random();
        int v, cyc, bcnt;
        bit clash;
        for (int i = 0; i < 15; i++) begin
            v = int'($urandom_range(0, 65535));
            launch(16'(v));
            wait_done(cyc, bcnt, clash);
            check_result("random", v, cyc, bcnt, clash);
        end
    endtask

    task automatic test_start_ignored();
        int ndone, kd;
        logic [19:0] seen;
        logic [19:0] r;
        ndone = 0;
        kd    = 0;
        seen  = '0;
        r     = ref_bcd(999, 5);
        launch(16'd999);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done5) begin
                ndone++;
                if (kd == 0) begin
                    kd   = k;
                    seen = bcd5;
                end
            end
            if (k == 3) begin
                start = 1'b1;
                bin   = 16'd42;
            end else begin
                start = 1'b0;
                bin   = 16'($urandom);
            end
        end
        n_checks += 4;
        if (ndone !== 1) begin
            n_fail++; $display("FAIL ignored_start done_count: got %0d want 1", ndone);
        end
        if (kd !== 16) begin
            n_fail++; $display("FAIL ignored_start latency: got %0d want 16", kd);
        end
        if (seen !== r) begin
            n_fail++; $display("FAIL ignored_start bcd: got %h want %h", seen, r);
        end
        if (busy5 !== 1'b0) begin
            n_fail++; $display("FAIL ignored_start queued: busy=%b want 0", busy5);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        bit clash;
        launch(16'd500);
        wait_done(cyc, bcnt, clash);
        n_checks += 2;
        if (cyc !== 16) begin
            n_fail++; $display("FAIL b2b first_latency: got %0d want 16", cyc);
        end
        if (bcd5 !== 20'h00500) begin
            n_fail++; $display("FAIL b2b first_bcd: got %h want 00500", bcd5);
        end
        start = 1'b1;
        bin   = 16'd77;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy5 !== 1'b1) begin
            n_fail++; $display("FAIL b2b accept_in_done_cycle: busy=%b want 1", busy5);
        end
        wait_done(cyc, bcnt, clash);
        check_result("b2b_second", 77, cyc, bcnt, clash);
    endtask

    task automatic test_reset_abort();
        int ndone, cyc, bcnt;
        bit clash;
        ndone = 0;
        launch(16'd4321);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks += 2;
        if ({busy5, done5, ovf5, bcd5} !== 23'd0) begin
            n_fail++; $display("FAIL abort_clear5: busy=%b done=%b ovf=%b bcd=%h want all 0", busy5, done5, ovf5, bcd5);
        end
        if ({busy4, done4, ovf4, bcd4} !== 19'd0) begin
            n_fail++; $display("FAIL abort_clear4: busy=%b done=%b ovf=%b bcd=%h want all 0", busy4, done4, ovf4, bcd4);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done5 || done4) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
        end
        launch(16'd4321);
        wait_done(cyc, bcnt, clash);
        check_result("after_abort", 4321, cyc, bcnt, clash);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
